axi4_mem_slave: RTL and testbench
=================================

AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, 32-bit words of storage; base address 0.
REQ-003 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-004 SHALL have port AXI_COMMON  input  axi4_pkg::common  bundle carrying ACLK (single clock, rising edge) and ARESETn (reset, asynchronous, active-low).
REQ-005 SHALL have port AXI_AW_M  input  axi4_pkg::aw_m  AWID, AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWVALID.
REQ-006 SHALL have port AXI_AW_S  output  axi4_pkg::aw_s  AWREADY.
REQ-007 SHALL have port AXI_W_M  input  axi4_pkg::w_m  WDATA[31:0], WSTRB[3:0], WLAST, WVALID.
REQ-008 SHALL have port AXI_W_S  output  axi4_pkg::w_s  WREADY.
REQ-009 SHALL have port AXI_B_M  input  axi4_pkg::b_m  BREADY.
REQ-010 SHALL have port AXI_B_S  output  axi4_pkg::b_s  BID, BRESP[1:0], BVALID.
REQ-011 SHALL have port AXI_AR_M  input  axi4_pkg::ar_m  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID.
REQ-012 SHALL have port AXI_AR_S  output  axi4_pkg::ar_s  ARREADY.
REQ-013 SHALL have port AXI_R_M  input  axi4_pkg::r_m  RREADY.
REQ-014 SHALL have port AXI_R_S  output  axi4_pkg::r_s  RID, RDATA[31:0], RRESP[1:0], RLAST, RVALID.

Function
REQ-015 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); one outstanding transaction per direction.
REQ-016 SHALL assert AWREADY only in W_IDLE; AW handshake latches ID/addr/len/size/burst, beat counter=0, err=0, next state W_DATA.
REQ-017 SHALL assert WREADY only in W_DATA; each W handshake writes bytes enabled by WSTRB to mem[addr[ADDR_W-1:2]] at that edge, unless err.
REQ-018 SHALL advance address per beat: FIXED unchanged; INCR +4; WRAP +4 wrapping within aligned (AWLEN+1)*4 window.
REQ-019 SHALL set err (no further writes) if AWSIZE!=2, AWBURST=3, WRAP with AWLEN not in {1,3,7,15}, or any beat address >= DEPTH_WORDS*4.
REQ-020 SHALL leave W_DATA on the beat with WLAST=1 or on beat AWLEN, whichever first; mismatch between them sets err.
REQ-021 SHALL in W_RESP drive BVALID=1, BID=latched ID, BRESP=OKAY(0) or SLVERR(2) if err; hold stable until BREADY, then W_IDLE.
REQ-022 SHALL assert ARREADY only in R_IDLE; AR handshake latches fields and fetches first beat; RVALID=1 on the next cycle.
REQ-023 SHALL hold RID/RDATA/RRESP/RLAST stable while RVALID=1 and RREADY=0; on handshake present next beat the following cycle (one cycle latency, no gap required).
REQ-024 SHALL assert RLAST on beat ARLEN; after its handshake return to R_IDLE.
REQ-025 SHALL apply REQ-018/019 rules to reads; erroneous beats return RDATA=0, RRESP=SLVERR, full ARLEN+1 beats still issued.
REQ-026 SHALL return pre-write data when a read beat fetch and a write beat target the same word in the same cycle.

Reset
REQ-027 SHALL on ARESETn=0 immediately force AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST to 0, BID/BRESP/RID/RDATA/RRESP to 0, FSMs to idle.
REQ-028 SHALL abandon any in-flight burst on reset with no B or R response; memory contents SHALL NOT be reset.
REQ-029 SHALL present AWREADY=1 and ARREADY=1 on the first rising edge after ARESETn deasserts.

Configuration
REQ-030 SHALL support WRAP bursts only when AXI4_MEM_SLAVE_WRAP_EN is defined; when undefined, WRAP (AWBURST/ARBURST=2) is treated as error per REQ-019.

Structure
REQ-031 SHALL place channel structs (aw_m/s, w_m/s, b_m/s, ar_m/s, r_m/s), burst-type and response constants in axi4_pkg.
REQ-032 SHALL factor burst address generation into sub-module axi4_burst_addr, instantiated once per direction.

Verification
REQ-033 INCR write AWADDR=0x10 AWLEN=3, data 0xA0..0xA3, WSTRB=F -> BRESP=0, BID echoed; INCR read same -> 4 beats 0xA0..0xA3, RLAST on beat 3.
REQ-034 Single write addr 0x20 data 0x11223344 WSTRB=0x5, prior 0 -> read returns 0x00220044.
REQ-035 WRAP write (macro defined) AWADDR=0x38 AWLEN=3 -> beats land at 0x38,0x3C,0x30,0x34; macro undefined -> BRESP=2, memory unchanged.
REQ-036 Read ARADDR=DEPTH_WORDS*4 ARLEN=1 -> 2 beats RRESP=2 RDATA=0; RREADY held low 5 cycles -> outputs stable.
REQ-037 WLAST asserted on beat 1 of AWLEN=3 -> BRESP=2; ARESETn pulsed low mid-write burst -> no BVALID, AWREADY=1 after release.

Source files
------------

// File: rtl/axi4_pkg.sv
// AXI4 channel bundles, burst/response encodings and FSM state types shared by the memory slave.
package axi4_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  typedef struct packed {
    logic ACLK;
    logic ARESETn;
  } common;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   AWID;
    logic [AXI_ADDR_W-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
  } aw_m;

  typedef struct packed {
    logic AWREADY;
  } aw_s;

  typedef struct packed {
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
  } w_m;

  typedef struct packed {
    logic WREADY;
  } w_s;

  typedef struct packed {
    logic BREADY;
  } b_m;

  typedef struct packed {
    logic [AXI_ID_W-1:0] BID;
    logic [1:0]          BRESP;
    logic                BVALID;
  } b_s;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   ARID;
    logic [AXI_ADDR_W-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
  } ar_m;

  typedef struct packed {
    logic ARREADY;
  } ar_s;

  typedef struct packed {
    logic RREADY;
  } r_m;

  typedef struct packed {
    logic [AXI_ID_W-1:0] RID;
    logic [31:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
  } r_s;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi4_burst_addr.sv
// Next-beat address and burst-legality check for one AXI direction; WRAP legal only with AXI4_MEM_SLAVE_WRAP_EN.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              cfg_err
);
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;

  assign incr = addr + ADDR_W'(4);
  // Legal wrap lengths are 2^n-1, so {len,2'b11} is exactly the byte mask of the window.
  assign mask = ADDR_W'({len, 2'b11});

  always_comb begin
    next_addr = incr;
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP)
      next_addr = (addr & ~mask) | (incr & mask);
  end

`ifdef AXI4_MEM_SLAVE_WRAP_EN
  logic wrap_len_ok;
  assign wrap_len_ok = len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign cfg_err = (size != 3'd2) || (burst == BURST_RSVD) || (burst == BURST_WRAP && !wrap_len_ok);
`else
  assign cfg_err = (size != 3'd2) || (burst == BURST_RSVD) || (burst == BURST_WRAP);
`endif
endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 word-memory slave, one outstanding burst per direction; WRAP support via AXI4_MEM_SLAVE_WRAP_EN.
// Latency: write beat lands at its W handshake edge; read beat valid one cycle after AR/R handshake.
// Backpressure: BVALID/RVALID and their payload hold until BREADY/RREADY; AW/AR accepted only when idle.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ID_W        = 4
) (
  input  common AXI_COMMON,
  input  aw_m   AXI_AW_M,
  output aw_s   AXI_AW_S,
  input  w_m    AXI_W_M,
  output w_s    AXI_W_S,
  input  b_m    AXI_B_M,
  output b_s    AXI_B_S,
  input  ar_m   AXI_AR_M,
  output ar_s   AXI_AR_S,
  input  r_m    AXI_R_M,
  output r_s    AXI_R_S
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;

  logic core_clk, arst_n;
  assign core_clk = AXI_COMMON.ACLK;
  assign arst_n   = AXI_COMMON.ARESETn;

  logic [31:0] mem [DEPTH_WORDS];

  // Write channel state
  wstate_t           w_state;
  logic              awready, wready, bvalid, w_err;
  logic [ID_W-1:0]   w_id, bid;
  logic [1:0]        bresp, w_burst;
  logic [2:0]        w_size;
  logic [7:0]        w_len, w_cnt;
  logic [ADDR_W-1:0] w_addr, w_next;
  logic              w_cfg_err, w_oob, w_hs, w_beat_err, w_len_end, w_mismatch, w_we;

  axi4_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
    .next_addr(w_next), .cfg_err(w_cfg_err)
  );

  assign w_oob      = {1'b0, w_addr} >= LIMIT;
  assign w_hs       = AXI_W_M.WVALID & wready;
  assign w_beat_err = w_err | w_cfg_err | w_oob;
  assign w_len_end  = (w_cnt == w_len);
  assign w_mismatch = AXI_W_M.WLAST ^ w_len_end;
  assign w_we       = w_hs & ~w_beat_err;

  always_ff @(posedge core_clk) begin
    if (w_we)
      for (int b = 0; b < 4; b++)
        if (AXI_W_M.WSTRB[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= AXI_W_M.WDATA[8*b +: 8];
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!awready) begin
            awready <= 1'b1;
          end else if (AXI_AW_M.AWVALID) begin
            w_id    <= AXI_AW_M.AWID[ID_W-1:0];
            w_addr  <= AXI_AW_M.AWADDR[ADDR_W-1:0];
            w_len   <= AXI_AW_M.AWLEN;
            w_size  <= AXI_AW_M.AWSIZE;
            w_burst <= AXI_AW_M.AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_beat_err | w_mismatch;
            if (AXI_W_M.WLAST || w_len_end) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= resp_of(w_beat_err | w_mismatch);
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (AXI_B_M.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel state
  rstate_t           r_state;
  logic              arready, rvalid, rlast;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata, f_data;
  logic [1:0]        rresp, r_burst, rb_burst;
  logic [2:0]        r_size, rb_size;
  logic [7:0]        r_len, r_cnt, rb_len;
  logic [ADDR_W-1:0] r_addr, r_next, f_addr;
  logic              r_idle, r_cfg_err, f_err;

  // While idle the checker looks at the incoming AR so the first beat is fetched at the handshake.
  assign r_idle   = (r_state == R_IDLE);
  assign rb_len   = r_idle ? AXI_AR_M.ARLEN   : r_len;
  assign rb_size  = r_idle ? AXI_AR_M.ARSIZE  : r_size;
  assign rb_burst = r_idle ? AXI_AR_M.ARBURST : r_burst;

  axi4_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
    .addr(r_addr), .len(rb_len), .size(rb_size), .burst(rb_burst),
    .next_addr(r_next), .cfg_err(r_cfg_err)
  );

  assign f_addr = r_idle ? AXI_AR_M.ARADDR[ADDR_W-1:0] : r_next;
  assign f_err  = r_cfg_err | ({1'b0, f_addr} >= LIMIT);
  assign f_data = f_err ? '0 : mem[f_addr[IDX_W+1:2]];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!arready) begin
            arready <= 1'b1;
          end else if (AXI_AR_M.ARVALID) begin
            rid     <= AXI_AR_M.ARID[ID_W-1:0];
            r_len   <= AXI_AR_M.ARLEN;
            r_size  <= AXI_AR_M.ARSIZE;
            r_burst <= AXI_AR_M.ARBURST;
            r_addr  <= f_addr;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (AXI_AR_M.ARLEN == 8'd0);
            rdata   <= f_data;
            rresp   <= resp_of(f_err);
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (AXI_R_M.RREADY) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= f_addr;
              r_cnt  <= r_cnt + 8'd1;
              rlast  <= ((r_cnt + 8'd1) == r_len);
              rdata  <= f_data;
              rresp  <= resp_of(f_err);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign AXI_AW_S.AWREADY = awready;
  assign AXI_W_S.WREADY   = wready;
  assign AXI_B_S.BID      = AXI_ID_W'(bid);
  assign AXI_B_S.BRESP    = bresp;
  assign AXI_B_S.BVALID   = bvalid;
  assign AXI_AR_S.ARREADY = arready;
  assign AXI_R_S.RID      = AXI_ID_W'(rid);
  assign AXI_R_S.RDATA    = rdata;
  assign AXI_R_S.RRESP    = rresp;
  assign AXI_R_S.RLAST    = rlast;
  assign AXI_R_S.RVALID   = rvalid;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: table of bursts with hand-computed results plus multi-cycle corner sequences.
module tb_axi4_mem_slave;
  import axi4_pkg::*;

`ifdef AXI4_MEM_SLAVE_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn;
  common com;
  aw_m awm; aw_s aws; w_m wm; w_s ws; b_m bm; b_s bs;
  ar_m arm; ar_s ars; r_m rm; r_s rs;

  assign com.ACLK    = aclk;
  assign com.ARESETn = aresetn;

  int n_cmp = 0;
  int n_fail = 0;

  axi4_mem_slave #(.ADDR_W(32), .DEPTH_WORDS(1024), .ID_W(4)) dut (
    .AXI_COMMON(com), .AXI_AW_M(awm), .AXI_AW_S(aws), .AXI_W_M(wm), .AXI_W_S(ws),
    .AXI_B_M(bm), .AXI_B_S(bs), .AXI_AR_M(arm), .AXI_AR_S(ars), .AXI_R_M(rm), .AXI_R_S(rs)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit               wr;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [2:0]       size;
    logic [3:0]       strb;
    logic [3:0][31:0] dat;
    logic [3:0][1:0]  rsp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(bit wr, logic [31:0] a, logic [7:0] l, logic [1:0] bu, logic [2:0] sz,
                             logic [3:0] st, logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                             logic [31:0] d3, logic [1:0] r0, logic [1:0] r1, logic [1:0] r2, logic [1:0] r3);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.burst = bu; v.size = sz; v.strb = st;
    v.dat = {d3, d2, d1, d0};
    v.rsp = {r3, r2, r1, r0};
    return v;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expired(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: handshake wait exceeded cycle budget", nm);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                         input logic [2:0] sz, input logic [3:0] id);
    int t = 0;
    awm.AWID = id; awm.AWADDR = a; awm.AWLEN = l; awm.AWSIZE = sz; awm.AWBURST = bu;
    awm.AWVALID = 1'b1;
    while (aws.AWREADY !== 1'b1 && t < 50) begin step(); t++; end
    if (t == 50) expired("aw_wait");
    step();
    awm.AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                         input logic [2:0] sz, input logic [3:0] id);
    int t = 0;
    arm.ARID = id; arm.ARADDR = a; arm.ARLEN = l; arm.ARSIZE = sz; arm.ARBURST = bu;
    arm.ARVALID = 1'b1;
    while (ars.ARREADY !== 1'b1 && t < 50) begin step(); t++; end
    if (t == 50) expired("ar_wait");
    step();
    arm.ARVALID = 1'b0;
  endtask

  // Sends beats 0..wl (WLAST on beat wl), then checks B, optionally stalling BREADY for bdly cycles.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] bu, input logic [2:0] sz, input logic [3:0] st,
                          input logic [3:0][31:0] d, input int wl, input int bdly,
                          input logic [3:0] id, input logic [1:0] exp_resp);
    int t;
    aw_send(a, l, bu, sz, id);
    for (int b = 0; b <= wl; b++) begin
      t = 0;
      wm.WDATA = d[b]; wm.WSTRB = st; wm.WLAST = (b == wl); wm.WVALID = 1'b1;
      while (ws.WREADY !== 1'b1 && t < 50) begin step(); t++; end
      if (t == 50) expired({tag, "_w_wait"});
      step();
    end
    wm.WVALID = 1'b0; wm.WLAST = 1'b0;
    chk({tag, "_wready_closed"}, ws.WREADY, 0);
    t = 0;
    while (bs.BVALID !== 1'b1 && t < 50) begin step(); t++; end
    if (t == 50) expired({tag, "_b_wait"});
    chk({tag, "_bresp"}, bs.BRESP, exp_resp);
    chk({tag, "_bid"}, bs.BID, id);
    for (int k = 0; k < bdly; k++) begin
      step();
      chk({tag, "_bvalid_hold"}, bs.BVALID, 1);
      chk({tag, "_bresp_hold"}, bs.BRESP, exp_resp);
    end
    bm.BREADY = 1'b1;
    step();
    bm.BREADY = 1'b0;
    chk({tag, "_bvalid_drop"}, bs.BVALID, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] bu, input logic [2:0] sz, input logic [3:0] id,
                         input logic [3:0][31:0] ed, input logic [3:0][1:0] er);
    int t;
    rm.RREADY = 1'b1;
    ar_send(a, l, bu, sz, id);
    chk({tag, "_rvalid_first"}, rs.RVALID, 1);
    for (int b = 0; b <= int'(l); b++) begin
      t = 0;
      while (rs.RVALID !== 1'b1 && t < 50) begin step(); t++; end
      if (t == 50) expired($sformatf("%s_r_wait%0d", tag, b));
      chk($sformatf("%s_rdata%0d", tag, b), rs.RDATA, ed[b]);
      chk($sformatf("%s_rresp%0d", tag, b), rs.RRESP, er[b]);
      chk($sformatf("%s_rlast%0d", tag, b), rs.RLAST, (b == int'(l)));
      chk($sformatf("%s_rid%0d", tag, b), rs.RID, id);
      step();
    end
    rm.RREADY = 1'b0;
    chk({tag, "_rvalid_done"}, rs.RVALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] d;
    logic [3:0][1:0]  r;
    aresetn = 1'b0;
    awm = '0; wm = '0; bm = '0; arm = '0; rm = '0;

    // Bursts with expected results; later entries rely on memory written by earlier ones.
    tbl.push_back(V(1, 32'h10, 3, BURST_INCR, 2, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0));
    tbl.push_back(V(0, 32'h10, 3, BURST_INCR, 2, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h20, 0, BURST_INCR, 2, 4'hF, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h20, 0, BURST_INCR, 2, 4'h5, 32'h11223344, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 32'h20, 0, BURST_INCR, 2, 4'hF, 32'h00220044, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h30, 3, BURST_INCR, 2, 4'hF, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h38, 3, BURST_WRAP, 2, 4'hF, 32'hB0, 32'hB1, 32'hB2, 32'hB3,
                    WRAP_ON ? 2'd0 : 2'd2, 0, 0, 0));
    tbl.push_back(V(0, 32'h30, 3, BURST_INCR, 2, 4'hF,
                    WRAP_ON ? 32'hB2 : 32'hC0, WRAP_ON ? 32'hB3 : 32'hC1,
                    WRAP_ON ? 32'hB0 : 32'hC2, WRAP_ON ? 32'hB1 : 32'hC3, 0, 0, 0, 0));
    tbl.push_back(V(0, 32'h38, 3, BURST_WRAP, 2, 4'hF,
                    WRAP_ON ? 32'hB0 : 32'h0, WRAP_ON ? 32'hB1 : 32'h0,
                    WRAP_ON ? 32'hB2 : 32'h0, WRAP_ON ? 32'hB3 : 32'h0,
                    WRAP_ON ? 2'd0 : 2'd2, WRAP_ON ? 2'd0 : 2'd2,
                    WRAP_ON ? 2'd0 : 2'd2, WRAP_ON ? 2'd0 : 2'd2));
    tbl.push_back(V(1, 32'h40, 2, BURST_FIXED, 2, 4'hF, 32'hD0, 32'hD1, 32'hD2, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 32'h40, 1, BURST_FIXED, 2, 4'hF, 32'hD2, 32'hD2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h44, 0, BURST_INCR, 2, 4'hF, 32'hE4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h44, 0, BURST_RSVD, 2, 4'hF, 32'hE5, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(V(0, 32'h40, 1, BURST_INCR, 2, 4'hF, 32'hD2, 32'hE4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h48, 0, BURST_INCR, 1, 4'hF, 32'hF0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(V(0, 32'h48, 0, BURST_INCR, 1, 4'hF, 32'h0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(V(1, 32'hFFC, 1, BURST_INCR, 2, 4'hF, 32'h77, 32'h88, 0, 0, 2, 0, 0, 0));
    tbl.push_back(V(0, 32'hFFC, 1, BURST_INCR, 2, 4'hF, 32'h77, 32'h0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(V(1, 32'h60, 0, BURST_INCR, 2, 4'hF, 32'h11111111, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 32'h30, 2, BURST_WRAP, 2, 4'hF, 32'h55, 32'h56, 32'h57, 0, 2, 0, 0, 0));
    tbl.push_back(V(0, 32'h30, 0, BURST_INCR, 2, 4'hF, WRAP_ON ? 32'hB2 : 32'hC0, 0, 0, 0, 0, 0, 0, 0));

    // Reset values, then ready on the first edge after release
    step(); step();
    chk("rst_awready", aws.AWREADY, 0);
    chk("rst_wready", ws.WREADY, 0);
    chk("rst_bvalid", bs.BVALID, 0);
    chk("rst_arready", ars.ARREADY, 0);
    chk("rst_rvalid", rs.RVALID, 0);
    chk("rst_rlast", rs.RLAST, 0);
    chk("rst_rdata", rs.RDATA, 0);
    aresetn = 1'b1;
    step();
    chk("rel_awready", aws.AWREADY, 1);
    chk("rel_arready", ars.ARREADY, 1);

    foreach (tbl[i]) begin
      if (tbl[i].wr)
        do_write($sformatf("v%0d", i), tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size,
                 tbl[i].strb, tbl[i].dat, int'(tbl[i].len), 0, 4'(i), tbl[i].rsp[0]);
      else
        do_read($sformatf("v%0d", i), tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size,
                4'(i), tbl[i].dat, tbl[i].rsp);
    end

    // Out-of-range read with RREADY held low: payload must stay put
    rm.RREADY = 1'b0;
    ar_send(32'h1000, 1, BURST_INCR, 2, 4'h9);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stall_rvalid%0d", k), rs.RVALID, 1);
      chk($sformatf("stall_rdata%0d", k), rs.RDATA, 0);
      chk($sformatf("stall_rresp%0d", k), rs.RRESP, 2);
      chk($sformatf("stall_rlast%0d", k), rs.RLAST, 0);
      chk($sformatf("stall_rid%0d", k), rs.RID, 9);
      if (k < 5) step();
    end
    rm.RREADY = 1'b1;
    step();
    chk("stall_b1_rvalid", rs.RVALID, 1);
    chk("stall_b1_rdata", rs.RDATA, 0);
    chk("stall_b1_rresp", rs.RRESP, 2);
    chk("stall_b1_rlast", rs.RLAST, 1);
    step();
    rm.RREADY = 1'b0;
    chk("stall_done", rs.RVALID, 0);

    // Early WLAST on beat 1 of a 4-beat burst, with BREADY stalled
    d = {32'h0, 32'h0, 32'h51, 32'h50};
    do_write("early_wlast", 32'h50, 3, BURST_INCR, 2, 4'hF, d, 1, 3, 4'h5, 2'd2);

    // Same-cycle read fetch and write beat to one word: read sees the old value
    aw_send(32'h60, 0, BURST_INCR, 2, 4'h7);
    chk("col_wready", ws.WREADY, 1);
    chk("col_arready", ars.ARREADY, 1);
    wm.WDATA = 32'h22222222; wm.WSTRB = 4'hF; wm.WLAST = 1'b1; wm.WVALID = 1'b1;
    arm.ARID = 4'h3; arm.ARADDR = 32'h60; arm.ARLEN = 0; arm.ARSIZE = 2; arm.ARBURST = BURST_INCR;
    arm.ARVALID = 1'b1;
    step();
    wm.WVALID = 1'b0; wm.WLAST = 1'b0; arm.ARVALID = 1'b0;
    chk("col_rvalid", rs.RVALID, 1);
    chk("col_rdata_old", rs.RDATA, 32'h11111111);
    chk("col_bvalid", bs.BVALID, 1);
    chk("col_bresp", bs.BRESP, 0);
    rm.RREADY = 1'b1; bm.BREADY = 1'b1;
    step();
    rm.RREADY = 1'b0; bm.BREADY = 1'b0;
    d = {32'h0, 32'h0, 32'h0, 32'h22222222};
    r = '0;
    do_read("col_after", 32'h60, 0, BURST_INCR, 2, 4'h3, d, r);

    // Reset in the middle of a write burst: no response, memory kept
    aw_send(32'h80, 3, BURST_INCR, 2, 4'h2);
    chk("mid_wready", ws.WREADY, 1);
    wm.WDATA = 32'h99; wm.WSTRB = 4'hF; wm.WLAST = 1'b0; wm.WVALID = 1'b1;
    step();
    wm.WDATA = 32'h9A;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_awready", aws.AWREADY, 0);
    chk("mid_rst_wready", ws.WREADY, 0);
    chk("mid_rst_bvalid", bs.BVALID, 0);
    chk("mid_rst_arready", ars.ARREADY, 0);
    wm.WVALID = 1'b0;
    step(); step();
    aresetn = 1'b1;
    step();
    chk("mid_rel_awready", aws.AWREADY, 1);
    chk("mid_rel_arready", ars.ARREADY, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_no_b%0d", k), bs.BVALID, 0);
      step();
    end
    d = {32'h0, 32'h0, 32'h0, 32'h99};
    do_read("mid_kept80", 32'h80, 0, BURST_INCR, 2, 4'h1, d, r);
    d = {32'h0, 32'h0, 32'h0, 32'hA0};
    do_read("mid_kept10", 32'h10, 0, BURST_INCR, 2, 4'h1, d, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
